alu: RTL and testbench
======================

Name: alu

Overview:
- Parameterised N-bit integer ALU for the processor datapath.
- Computes arithmetic, logic, shift or move operations on operands a and b, selected by a 4-bit ctrl code.
- Produces a result word and NZCV condition flags.
- Result and flags are registered: one clock of latency from the sampled inputs.

Parameters:
N, 32, datapath width in bits (N >= 2, power of two).

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  when high, a/b/ctrl are sampled and the outputs update on the next rising edge.
a  input  N  operand A.
b  input  N  operand B; its low log2(N) bits are the shift amount for shift ops.
ctrl  input  4  operation select.
result  output  N  registered operation result.
flags  output  4  registered {neg[3], zero[2], carry[1], overflow[1:0]→[0]} = {N,Z,C,V}.
valid  output  1  high for one cycle when result/flags hold a new value (en delayed by one cycle).

Behaviour:
- Reset: while rst is high (asynchronous assert), result=0, flags=4'b0000, valid=0. Release takes effect at the next clk edge.
- Latency: en=1 at edge k captures the operation. result, flags and valid=1 are visible after edge k. en=0 holds result and flags and drives valid=0.
- Opcodes:
  - 0000 ADD: a+b
  - 0001 SUB: a-b
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT: ~a
  - 0110 SLL: a << sh
  - 0111 SRL: logical a >> sh
  - 1000 SRA: arithmetic a >>> sh
  - 1001 MUL: low N bits of a*b, unsigned
  - 1010 MOV: b
  - 1011-1111: reserved; result=0, flags=0000
- sh = b[log2(N)-1:0]. Upper bits of b are ignored for shift ops.
- N flag = result[N-1]. Z flag = (result==0). Both apply to all defined opcodes, including MUL and MOV.
- ADD: computed as an (N+1)-bit sum.
  - C = bit N of the sum (unsigned carry-out).
  - V = a[N-1]==b[N-1] && result[N-1]!=a[N-1].
- SUB: computed as a + ~b + 1.
  - C = carry-out, i.e. 1 means no borrow (a >= b unsigned).
  - V = a[N-1]!=b[N-1] && result[N-1]!=a[N-1].
- Shifts:
  - C = last bit shifted out (SLL: a[N-sh]; SRL/SRA: a[sh-1]).
  - C = 0 when sh = 0.
  - V = 0.
- Logic ops, NOT, MUL, MOV: C = 0, V = 0.
- Wrap-around: ADD and SUB wrap modulo 2^N. MUL discards the high half.
- Reset asserted mid-operation: the pending capture is discarded and outputs go to reset values immediately.
- Changes on a/b/ctrl while en=0 have no effect on the outputs.

Decomposition:
- Package alu_pkg:
  - enum alu_op_e with the 4-bit opcodes above.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, alu_addsub: N-bit adder/subtractor with inputs a, b, sub and outputs sum, carry, overflow. Shared by ADD and SUB.
- Shifter, logic, MUL, flag generation and output registers live in alu.

Test Plan:
- ADD 10+256, en=1 → next cycle result=266, flags=0000, valid=1.
- SUB 10-10 → result=0, flags=0110 (Z=1, C=1: no borrow).
- SUB 1-10 → result=0xFFFFFFF7 (-9), flags=1000 (N=1, C=0: borrow).
- ADD 24+(-10) (b=0xFFFFFFF6) → result=14, flags=0010 (C=1, V=0).
- Overflow cases:
  - ADD 0x7FFFFFFF+1 → result=0x80000000, flags=1001.
  - SUB 0x80000000-1 → result=0x7FFFFFFF, flags=0011.
- Shift, reset and hold cases:
  - SLL a=0x80000001, b=1 → result=0x00000002, C=1.
  - SRA a=0x80000000, b=4 → result=0xF8000000, N=1.
  - Assert rst mid-stream → result=0, flags=0, valid=0 immediately.
  - en=0 with new inputs → outputs hold, valid=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag bit positions for the datapath ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd = 4'b0000,
    OpSub = 4'b0001,
    OpAnd = 4'b0010,
    OpOr  = 4'b0011,
    OpXor = 4'b0100,
    OpNot = 4'b0101,
    OpSll = 4'b0110,
    OpSrl = 4'b0111,
    OpSra = 4'b1000,
    OpMul = 4'b1001,
    OpMov = 4'b1010
  } alu_op_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_addsub.sv
// N-bit adder/subtractor shared by ADD and SUB; subtraction is a + ~b + 1.
module alu_addsub #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         overflow
);

  logic [N-1:0] b_eff;
  logic [N:0]   full;

  always_comb begin
    b_eff    = sub ? ~b : b;
    full     = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
    sum      = full[N-1:0];
    carry    = full[N];
    // Same-sign operands (after inversion) producing a different-sign result
    overflow = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
  end

endmodule

// File: rtl/alu.sv
// Registered N-bit integer ALU producing a result word and {N,Z,C,V} flags.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ctrl,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         valid
);

  localparam int unsigned ShW = $clog2(N);

  logic [ShW-1:0] sh;
  logic [N-1:0]   as_sum;
  logic           as_carry;
  logic           as_ovf;
  logic [N:0]     sll_ext;
  logic [N:0]     srl_ext;
  logic [N:0]     sra_ext;
  logic [N-1:0]   mul_lo;
  logic [N-1:0]   res_d;
  logic           c_d;
  logic           v_d;
  logic           defined;
  logic [3:0]     flags_d;

  assign sh = b[ShW-1:0];

  alu_addsub #(
    .N(N)
  ) u_addsub (
    .a       (a),
    .b       (b),
    .sub     (ctrl == OpSub),
    .sum     (as_sum),
    .carry   (as_carry),
    .overflow(as_ovf)
  );

  // One extra bit beyond the word catches the last bit shifted out (zero when sh = 0)
  always_comb begin
    sll_ext = {1'b0, a} << sh;
    srl_ext = {a, 1'b0} >> sh;
    sra_ext = $unsigned($signed({a, 1'b0}) >>> sh);
    mul_lo  = a * b;
  end

  always_comb begin
    res_d   = '0;
    c_d     = 1'b0;
    v_d     = 1'b0;
    defined = 1'b1;
    case (ctrl)
      OpAdd, OpSub: begin
        res_d = as_sum;
        c_d   = as_carry;
        v_d   = as_ovf;
      end
      OpAnd: res_d = a & b;
      OpOr:  res_d = a | b;
      OpXor: res_d = a ^ b;
      OpNot: res_d = ~a;
      OpSll: begin
        res_d = sll_ext[N-1:0];
        c_d   = sll_ext[N];
      end
      OpSrl: begin
        res_d = srl_ext[N:1];
        c_d   = srl_ext[0];
      end
      OpSra: begin
        res_d = sra_ext[N:1];
        c_d   = sra_ext[0];
      end
      OpMul: res_d = mul_lo;
      OpMov: res_d = b;
      default: defined = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = 4'b0000;
    if (defined) begin
      flags_d[FLAG_N] = res_d[N-1];
      flags_d[FLAG_Z] = (res_d == '0);
      flags_d[FLAG_C] = c_d;
      flags_d[FLAG_V] = v_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      flags  <= 4'b0000;
      valid  <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        result <= res_d;
        flags  <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases plus randomized ops against a reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  ctrl;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        valid;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_res;
  logic [3:0]  exp_flg;

  alu #(
    .N(32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .a     (a),
    .b     (b),
    .ctrl  (ctrl),
    .result(result),
    .flags (flags),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Reference computed with wide integer arithmetic; returns {flags, result}
  function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    longint unsigned ux, uy, w;
    longint          sx, sy, s;
    int unsigned     sh;
    logic [31:0]     r;
    logic            c, v;
    ux = 64'(x);
    uy = 64'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = y % 32;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      4'd0: begin
        w = ux + uy; r = w[31:0]; c = w[32];
        s = sx + sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r = x - y; c = (ux >= uy);
        s = sx - sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = ~x;
      4'd6: begin
        w = ux << sh; r = w[31:0]; c = w[32];
      end
      4'd7: begin
        r = x >> sh; c = (sh != 0) ? x[sh-1] : 1'b0;
      end
      4'd8: begin
        s = sx >>> sh; r = s[31:0]; c = (sh != 0) ? x[sh-1] : 1'b0;
      end
      4'd9: begin
        w = ux * uy; r = w[31:0];
      end
      4'd10: r = y;
      default: return 36'd0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y);
    logic [35:0] m;
    @(negedge clk);
    en = 1'b1; ctrl = op; a = x; b = y;
    m = model(op, x, y);
    exp_flg = m[35:32];
    exp_res = m[31:0];
    @(posedge clk);
    #1;
    check({tag, ".result"}, 64'(result), 64'(exp_res));
    check({tag, ".flags"}, 64'(flags), 64'(exp_flg));
    check({tag, ".valid"}, 64'(valid), 64'd1);
  endtask

  logic [31:0] edge_vals [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h1F};

  initial begin
    rst = 1'b1; en = 1'b0; a = '0; b = '0; ctrl = '0;
    #1;
    check("reset.result", 64'(result), 64'd0);
    check("reset.flags", 64'(flags), 64'd0);
    check("reset.valid", 64'(valid), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases with literal expectations
    do_op("add10_256", 4'd0, 32'd10, 32'd256);
    check("add10_256.lit", 64'({flags, result}), 64'({4'b0000, 32'd266}));
    do_op("sub10_10", 4'd1, 32'd10, 32'd10);
    check("sub10_10.lit", 64'({flags, result}), 64'({4'b0110, 32'd0}));
    do_op("sub1_10", 4'd1, 32'd1, 32'd10);
    check("sub1_10.lit", 64'({flags, result}), 64'({4'b1000, 32'hFFFFFFF7}));
    do_op("add24_m10", 4'd0, 32'd24, 32'hFFFFFFF6);
    check("add24_m10.lit", 64'({flags, result}), 64'({4'b0010, 32'd14}));
    do_op("add_ovf", 4'd0, 32'h7FFFFFFF, 32'd1);
    check("add_ovf.lit", 64'({flags, result}), 64'({4'b1001, 32'h80000000}));
    do_op("sub_ovf", 4'd1, 32'h80000000, 32'd1);
    check("sub_ovf.lit", 64'({flags, result}), 64'({4'b0011, 32'h7FFFFFFF}));
    do_op("sll", 4'd6, 32'h80000001, 32'd1);
    check("sll.lit", 64'({flags, result}), 64'({4'b0010, 32'h00000002}));
    do_op("sra", 4'd8, 32'h80000000, 32'd4);
    check("sra.lit", 64'({flags, result}), 64'({4'b1000, 32'hF8000000}));
    do_op("sll_sh0", 4'd6, 32'h80000001, 32'h20);
    do_op("srl_sh31", 4'd7, 32'h80000001, 32'd31);
    do_op("reserved", 4'd13, 32'h0, 32'h0);
    check("reserved.lit", 64'({flags, result}), 64'd0);

    // Hold: en=0 with new inputs leaves outputs unchanged
    do_op("pre_hold", 4'd3, 32'h00F0, 32'h0F00);
    @(negedge clk);
    en = 1'b0; ctrl = 4'd0; a = 32'h12345678; b = 32'h9ABCDEF0;
    @(posedge clk);
    #1;
    check("hold.result", 64'(result), 64'(exp_res));
    check("hold.flags", 64'(flags), 64'(exp_flg));
    check("hold.valid", 64'(valid), 64'd0);

    // Randomized ops, biased toward edge operands
    for (int i = 0; i < 400; i++) begin
      logic [31:0] x, y;
      x = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      do_op("rand", 4'($urandom_range(0, 15)), x, y);
    end

    // Reset mid-operation: pending capture discarded, outputs clear immediately
    @(negedge clk);
    en = 1'b1; ctrl = 4'd0; a = 32'd5; b = 32'd6;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid.result", 64'(result), 64'd0);
    check("rst_mid.flags", 64'(flags), 64'd0);
    check("rst_mid.valid", 64'(valid), 64'd0);
    @(posedge clk);
    #1;
    check("rst_edge.result", 64'(result), 64'd0);
    check("rst_edge.valid", 64'(valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    do_op("post_rst", 4'd9, 32'd7, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
